// File: rtl/harris_frame_seq.sv
// Multi-frame sequencer for the Harris accelerator. Each frame is handled in three steps:
// the host loads the img BRAM, the accelerator runs over it, and the host drains the result.
module harris_frame_seq #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int FRAME_W = 16,
    parameter int TIMEOUT = 1048576
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [FRAME_W-1:0] cmd_nframes,
    output logic               load_grant,
    input  logic               load_done,
    input  logic               host_img_we,
    input  logic [ADDR_W-1:0]  host_img_addr,
    input  logic [DATA_W-1:0]  host_img_wdata,
    output logic               res_valid,
    input  logic               res_ack,
    output logic               acc_start,
    input  logic               acc_ready,
    input  logic               acc_done,
    input  logic               acc_img_ce,
    input  logic [ADDR_W-1:0]  acc_img_addr,
    output logic               img_ce,
    output logic               img_we,
    output logic [ADDR_W-1:0]  img_addr,
    output logic [DATA_W-1:0]  img_wdata,
    output logic               err,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam int              WD_W    = 21;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [2:0]         state, next_state;
    logic [FRAME_W-1:0] nframes_q;
    logic [FRAME_W-1:0] frame_cnt_inc;
    logic [WD_W-1:0]    wd_cnt;
    logic               cmd_accept;
    logic               wd_active;
    logic               wd_hit;

    assign cmd_ready     = (state == S_IDLE) || (state == S_ERR);
    assign cmd_accept    = cmd_valid && cmd_ready;
    assign load_grant    = (state == S_LOAD);
    assign res_valid     = (state == S_DRAIN);
    assign frame_cnt_inc = frame_cnt + FRAME_W'(1);
    assign wd_active     = (state == S_START) || (state == S_RUN);
    assign wd_hit        = (TIMEOUT != 0) && wd_active && (wd_cnt == WD_LAST);

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_ERR: begin
                if (cmd_accept) next_state = (cmd_nframes == '0) ? S_IDLE : S_LOAD;
            end
            S_LOAD: begin
                if (load_done) next_state = S_START;
            end
            S_START: begin
                if (wd_hit)         next_state = S_ERR;
                else if (acc_ready) next_state = acc_done ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                if (wd_hit)        next_state = S_ERR;
                else if (acc_done) next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (res_ack) next_state = (frame_cnt_inc == nframes_q) ? S_IDLE : S_LOAD;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            nframes_q <= '0;
            wd_cnt    <= '0;
            acc_start <= 1'b0;
            err       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= next_state;
            acc_start <= (next_state == S_START);

            if (state != S_START && next_state == S_START) wd_cnt <= '0;
            else if (wd_active)                            wd_cnt <= wd_cnt + WD_W'(1);

            if (cmd_accept) begin
                err       <= 1'b0;
                nframes_q <= cmd_nframes;
                if (cmd_nframes != '0) frame_cnt <= '0;
            end else if (wd_hit) begin
                err <= 1'b1;
            end

            if (state == S_DRAIN && res_ack) frame_cnt <= frame_cnt_inc;
        end
    end

    // The BRAM port belongs to the host only in LOAD and to the accelerator only in RUN.
    always_comb begin
        img_ce    = 1'b0;
        img_we    = 1'b0;
        img_addr  = '0;
        img_wdata = '0;
        case (state)
            S_LOAD: begin
                img_ce    = host_img_we;
                img_we    = host_img_we;
                img_addr  = host_img_addr;
                img_wdata = host_img_wdata;
            end
            S_RUN: begin
                img_ce   = acc_img_ce;
                img_addr = acc_img_addr;
            end
            default: ;
        endcase
    end

endmodule
